// File: rtl/isa_shared_pkg.sv
// isa_shared: immediate-format encodings shared by the decode stage and its users
package isa_shared;
  typedef enum logic [2:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_U     = 3'd3,
    IMM_J     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_op_e;
  localparam imm_op_e IMM_3120 = IMM_I;
endpackage

// File: rtl/imm_decode.sv
// imm_decode: combinational immediate extraction; ports: instruction/imm_op in, imm/illegal out
module imm_decode
  import isa_shared::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [31:0]           instruction,
  input  logic [2:0]            imm_op,
  output logic [DATA_WIDTH-1:0] imm,
  output logic                  illegal
);
  logic s;
  logic unused_opcode;
  assign s = instruction[31];
  assign unused_opcode = ^instruction[6:0];
  assign illegal = imm_op == IMM_RSVD;
  assign imm =
    imm_op == IMM_I     ? {{(DATA_WIDTH-12){s}}, instruction[31:20]} :
    imm_op == IMM_S     ? {{(DATA_WIDTH-12){s}}, instruction[31:25], instruction[11:7]} :
    imm_op == IMM_B     ? {{(DATA_WIDTH-13){s}}, instruction[31], instruction[7], instruction[30:25], instruction[11:8], 1'b0} :
    imm_op == IMM_U     ? {{(DATA_WIDTH-32){s}}, instruction[31:12], 12'b0} :
    imm_op == IMM_J     ? {{(DATA_WIDTH-21){s}}, instruction[31], instruction[19:12], instruction[20], instruction[30:21], 1'b0} :
    imm_op == IMM_SHAMT ? {{(DATA_WIDTH-6){1'b0}}, DATA_WIDTH == 64 ? instruction[25] : 1'b0, instruction[24:20]} :
    imm_op == IMM_ZIMM  ? {{(DATA_WIDTH-5){1'b0}}, instruction[19:15]} :
                          '0;
endmodule

// File: rtl/imm_gen_stage.sv
// imm_gen_stage: immediate decode followed by a 2-entry skid buffer; valid/ready in, valid/ready out with imm, tag, illegal
module imm_gen_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic [2:0]            imm_op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] imm_data,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  imm_illegal
);
  localparam int EW = DATA_WIDTH + TAG_WIDTH + 1;
  logic [DATA_WIDTH-1:0] dec_imm;
  logic                  dec_ill;
  logic [EW-1:0]         in_e, out_q, out_d, skid_q, skid_d;
  logic                  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, in_ready_q;
  logic                  acc, dlv;
  imm_decode #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
    .instruction(instruction),
    .imm_op     (imm_op),
    .imm        (dec_imm),
    .illegal    (dec_ill)
  );
  assign in_e = {dec_ill, in_tag, dec_imm};
  assign acc  = in_valid && in_ready_q;
  assign dlv  = out_valid_q && out_ready;
  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    if (skid_valid_q && dlv) begin
      out_d        = skid_q;
      skid_valid_d = 1'b0;
    end else if (acc && (!out_valid_q || dlv)) begin
      out_d       = in_e;
      out_valid_d = 1'b1;
    end else if (acc) begin
      skid_d       = in_e;
      skid_valid_d = 1'b1;
    end else if (dlv) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign {imm_illegal, out_tag, imm_data} = out_q;
endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, giving the immediate output width; legal values are 32 and 64.
REQ-002 SHALL have parameter TAG_WIDTH, default 32, giving the width of the sideband tag (PC) passed through with the instruction.
REQ-003 SHALL have port clk  input  1  single clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  upstream instruction valid.
REQ-006 SHALL have port in_ready  output  1  stage can accept an instruction.
REQ-007 SHALL have port instruction  input  32  raw instruction word.
REQ-008 SHALL have port imm_op  input  3  immediate format select.
REQ-009 SHALL have port in_tag  input  TAG_WIDTH  sideband tag.
REQ-010 SHALL have port out_valid  output  1  immediate result valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts the result.
REQ-012 SHALL have port imm_data  output  DATA_WIDTH  extended immediate.
REQ-013 SHALL have port out_tag  output  TAG_WIDTH  tag matching imm_data.
REQ-014 SHALL have port imm_illegal  output  1  imm_op was the reserved encoding.

Function
REQ-015 SHALL decode imm_op as follows; every signed form is sign-extended from bit 31 of instruction up to DATA_WIDTH.
- 0 I: instruction[31:20]
- 1 S: {[31:25],[11:7]}
- 2 B: {[31],[7],[30:25],[11:8],0}
- 3 U: {[31:12], 12 zeros}
- 4 J: {[31],[19:12],[20],[30:21],0}
REQ-016 SHALL decode imm_op 5 (SHAMT) as instruction[25:20] zero-extended when DATA_WIDTH=64, and instruction[24:20] zero-extended when DATA_WIDTH=32.
REQ-017 SHALL decode imm_op 6 (ZIMM, CSR) as instruction[19:15] zero-extended.
REQ-018 SHALL, for imm_op 7 (reserved), produce imm_data=0 with imm_illegal=1; for imm_op 0-6, imm_illegal SHALL be 0.
REQ-019 SHALL accept a transfer on any rising edge where in_valid && in_ready.
REQ-020 SHALL deliver a transfer on any rising edge where out_valid && out_ready.
REQ-021 SHALL have a latency of 1 cycle: a transfer accepted at edge N is presented on imm_data/out_tag/imm_illegal with out_valid=1 after edge N.
REQ-022 SHALL buffer through a 2-entry skid (output register plus skid register), giving full throughput of 1 per cycle when out_ready stays high.
REQ-023 SHALL drive in_ready from a register, equal to !skid_full, with no combinational path from out_ready.
REQ-024 SHALL write an item accepted while the output register holds an undelivered result into the skid register; in_ready SHALL be 0 from the next cycle.
REQ-025 SHALL, on delivery with the skid register full, move the skid content into the output register in the same edge; in_ready SHALL be 1 from the next cycle.
REQ-026 SHALL preserve FIFO order at all times; no item is dropped or duplicated.
REQ-027 SHALL hold imm_data, out_tag and imm_illegal stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, on simultaneous accept and deliver with the skid empty, load the new item directly into the output register with out_valid staying 1.
REQ-029 SHALL treat output values while out_valid=0 as don't-care, except after reset (see REQ-031).

Reset
REQ-030 SHALL, on rst=1 at a rising edge, discard both entries, clear out_valid, and set in_ready=1; in_valid is ignored during that cycle.
REQ-031 SHALL make imm_data, out_tag and imm_illegal 0 after reset.
REQ-032 SHALL behave identically for reset asserted mid-backpressure (full skid): no stale item appears after rst deasserts.

Structure
REQ-033 SHALL define the imm_op encodings IMM_I (=IMM_3120), IMM_S, IMM_B, IMM_U, IMM_J, IMM_SHAMT, IMM_ZIMM and IMM_RSVD in the shared isa_shared package.
REQ-034 SHALL implement the combinational decoder as a sub-module, imm_decode, instantiated once ahead of the skid buffer.

Verification
REQ-035 SHALL cover decode of every format: 0xFFF00093/I->0xFFFFFFFF; 0x80000023/S->0xFFFFF800; 0x80000063/B->0xFFFFF000; 0x12345037/U->0x12345000; 0x8000006F/J->0xFFF00000; 0x01F00013/SHAMT->0x1F.
REQ-036 SHALL cover DATA_WIDTH=64: 0xFFF00093/I->0xFFFFFFFFFFFFFFFF; 0x03F00013/SHAMT->0x3F.
REQ-037 SHALL cover backpressure: out_ready=0 with tags 1,2,3 offered back-to-back -> in_ready=0 after tag 2 is accepted; tag 3 is held; out_ready=1 -> outputs 1,2,3 in order, one per cycle.
REQ-038 SHALL cover streaming: 100 items with out_ready=1 continuously -> 100 deliveries in 101 cycles, in_ready never 0.
REQ-039 SHALL cover reserved op: imm_op=7 -> imm_data=0, imm_illegal=1.
REQ-040 SHALL cover reset with the skid full -> out_valid=0 and in_ready=1 in the next cycle, and the next accepted item is the first one delivered.
